// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions.
// Holds the MEM-stage FSM state type and the write-back data-select encoding.
package cpu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } mem_state_t;

  typedef enum logic [1:0] {
    WbSelAlu,
    WbSelLoad,
    WbSelLink
  } wb_sel_t;

  // Link data beats load data, which beats the ALU result.
  function automatic wb_sel_t wb_select(input logic link_en, input logic mem_to_reg);
    if (link_en) begin
      return WbSelLink;
    end else if (mem_to_reg) begin
      return WbSelLoad;
    end
    return WbSelAlu;
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Clear/enable cycle counter with a terminal-count flag.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset
//   clr_i  - clear to zero (wins over en_i)
//   en_i   - count one cycle
//   tc_o   - count has reached TermCount-1
module mem_timeout_cnt #(
  parameter int unsigned TermCount = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = (TermCount > 1) ? $clog2(TermCount) : 1;

  logic [CntW-1:0] cnt_d, cnt_q;

  assign tc_o = (cnt_q == CntW'(TermCount - 1));

  // Saturate at the terminal count so the flag cannot wrap away.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word load/store handshake with the data-memory port,
// upstream stall while an access is outstanding, and the registered result to WB.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   mem_read_in .. link_data_in - control/data from the EX/MEM register (held while stalled)
//   dmem_req/we/addr/wdata      - combinational request to data memory
//   dmem_ready/rvalid/rdata     - data-memory acceptance and load response
//   mem_stall                   - combinational hold for PC, IF/ID, ID/EX, EX/MEM
//   reg_write_out, dest_reg_out, wb_data_out - registered write-back outputs
//   misalign_err, bus_err       - registered single-cycle error pulses
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic              link_en_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       write_data_in,
  input  logic [4:0]        dest_reg_in,
  input  logic [31:0]       link_data_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
  output logic              reg_write_out,
  output logic [4:0]        dest_reg_out,
  output logic [31:0]       wb_data_out,
  output logic              misalign_err,
  output logic              bus_err
);

  mem_state_t  state_d, state_q;
  logic        reg_write_d, reg_write_q;
  logic [4:0]  dest_reg_d, dest_reg_q;
  logic [31:0] wb_data_d, wb_data_q;
  logic        misalign_d, misalign_q;
  logic        bus_err_d, bus_err_q;

  logic        is_mem, is_store, aligned, timeout_tc, wb_en;
  logic [31:0] wb_mux;

  assign is_mem   = mem_read_in | mem_write_in;
  // Read and write together is treated as a load.
  assign is_store = mem_write_in & ~mem_read_in;
  assign aligned  = (alu_result_in[1:0] == 2'b00);

  assign dmem_we    = is_store;
  assign dmem_addr  = alu_result_in;
  assign dmem_wdata = write_data_in;

  always_comb begin
    wb_mux = alu_result_in;
    unique case (wb_select(link_en_in, mem_to_reg_in))
      WbSelLink: wb_mux = link_data_in;
      WbSelLoad: wb_mux = dmem_rdata;
      default:   wb_mux = alu_result_in;
    endcase
  end

  // Counter sits at zero in IDLE and runs for every REQ/WAIT cycle.
  mem_timeout_cnt #(
    .TermCount (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (state_d == StIdle),
    .en_i  (state_q != StIdle),
    .tc_o  (timeout_tc)
  );

  // FSM next state, memory request and stall.
  always_comb begin
    state_d    = state_q;
    dmem_req   = 1'b0;
    mem_stall  = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    wb_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!is_mem) begin
          wb_en = 1'b1;
        end else if (!aligned) begin
          misalign_d = 1'b1;
        end else begin
          dmem_req = 1'b1;
          if (dmem_ready && is_store) begin
            wb_en = 1'b1;
          end else if (dmem_ready) begin
            state_d   = StWait;
            mem_stall = 1'b1;
          end else begin
            state_d   = StReq;
            mem_stall = 1'b1;
          end
        end
      end
      StReq: begin
        if (timeout_tc) begin
          // Abort drops the request outright; a same-cycle ready is ignored.
          state_d   = StIdle;
          bus_err_d = 1'b1;
        end else begin
          dmem_req = 1'b1;
          if (dmem_ready && is_store) begin
            state_d = StIdle;
            wb_en   = 1'b1;
          end else if (dmem_ready) begin
            state_d   = StWait;
            mem_stall = 1'b1;
          end else begin
            mem_stall = 1'b1;
          end
        end
      end
      StWait: begin
        if (dmem_rvalid) begin
          state_d = StIdle;
          wb_en   = 1'b1;
        end else if (timeout_tc) begin
          state_d   = StIdle;
          bus_err_d = 1'b1;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write-back register next state: stall cycles and errors insert a bubble
  // that keeps dest/data but clears the write enable.
  always_comb begin
    reg_write_d = 1'b0;
    dest_reg_d  = dest_reg_q;
    wb_data_d   = wb_data_q;
    if (wb_en) begin
      reg_write_d = reg_write_in;
      dest_reg_d  = dest_reg_in;
      wb_data_d   = wb_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      reg_write_q <= 1'b0;
      dest_reg_q  <= '0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_write_q <= reg_write_d;
      dest_reg_q  <= dest_reg_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign reg_write_out = reg_write_q;
  assign dest_reg_out  = dest_reg_q;
  assign wb_data_out   = wb_data_q;
  assign misalign_err  = misalign_q;
  assign bus_err       = bus_err_q;

endmodule
